// File: rtl/ysyx_23060332_pkg.sv
// Shared definitions for the ysyx_23060332 write-back unit.
//   wbu_state_e      : write-back FSM states (IDLE, REQ, WAIT, WRITE)
//   F3_*             : RV32 load funct3 codes (LB, LH, LW, LBU, LHU)
//   load_misaligned  : alignment/legality check for a load funct3 and addr[1:0]
package ysyx_23060332_pkg;

  typedef enum logic [1:0] {
    WBU_IDLE  = 2'd0,
    WBU_REQ   = 2'd1,
    WBU_WAIT  = 2'd2,
    WBU_WRITE = 2'd3
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Reserved load codes (3, 6, 7) are reported as misaligned so that no
  // memory request is ever issued for them.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060332_ldext.sv
// Combinational load data extraction: selects the byte or halfword addressed
// by addr[1:0] out of a read word and sign- or zero-extends it.
// Ports:
//   rdata_i   : word returned by memory
//   funct3_i  : load size/sign code
//   addr_lo_i : low two bits of the original effective address
//   data_o    : extended value for the register file
module ysyx_23060332_ldext
  import ysyx_23060332_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: accepts execute results, writes ALU results straight to
// the register file, and performs RV32 loads through a word-aligned
// request/response memory port before writing the extracted value.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : upstream handshake (ready only in IDLE)
//   in_rd, in_data           : destination register, ALU result or load address
//   in_is_load, in_funct3    : load flag and load size/sign code
//   mem_req_valid/ready      : read request handshake, mem_addr word-aligned
//   mem_rsp_valid, mem_rdata : read response
//   wen, rd, wdata           : register-file write port (never writes x0)
//   misalign                 : one-cycle pulse for a rejected load
// Optional: define YSYX_23060332_WB_FWD_EN to add fwd_valid/fwd_rd/fwd_data,
// combinational mirrors of wen/rd/wdata for decode bypass.
module ysyx_23060332_wbu
  import ysyx_23060332_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wen,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] wdata,
  output logic              misalign
`ifdef YSYX_23060332_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  wbu_state_e        state_q, state_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_lo_q, ld_lo_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              misalign_q, misalign_d;
  logic              accept;
  logic [DATA_W-1:0] ext_data;

  assign in_ready      = (state_q == WBU_IDLE);
  assign accept        = in_valid && in_ready;
  assign mem_req_valid = (state_q == WBU_REQ);
  assign mem_addr      = mem_addr_q;
  assign wen           = wen_q;
  assign rd            = rd_q;
  assign wdata         = wdata_q;
  assign misalign      = misalign_q;

`ifdef YSYX_23060332_WB_FWD_EN
  assign fwd_valid = wen_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wdata_q;
`endif

  ysyx_23060332_ldext #(
    .DATA_W (DATA_W)
  ) u_ldext (
    .rdata_i   (mem_rdata),
    .funct3_i  (ld_f3_q),
    .addr_lo_i (ld_lo_q),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    mem_addr_d = mem_addr_q;
    wen_d      = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    misalign_d = 1'b0;

    case (state_q)
      WBU_IDLE: begin
        if (accept) begin
          if (!in_is_load) begin
            wen_d   = (in_rd != '0);
            rd_d    = in_rd;
            wdata_d = in_data;
          end else if (load_misaligned(in_funct3, in_data[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            ld_rd_d    = in_rd;
            ld_f3_d    = in_funct3;
            ld_lo_d    = in_data[1:0];
            mem_addr_d = {in_data[DATA_W-1:2], 2'b00};
            state_d    = WBU_REQ;
          end
        end
      end
      WBU_REQ: begin
        if (mem_req_ready) state_d = WBU_WAIT;
      end
      WBU_WAIT: begin
        if (mem_rsp_valid) begin
          // Capture the extracted value now so it is presented during WRITE.
          wen_d   = (ld_rd_q != '0);
          rd_d    = ld_rd_q;
          wdata_d = ext_data;
          state_d = WBU_WRITE;
        end
      end
      WBU_WRITE: begin
        state_d = WBU_IDLE;
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WBU_IDLE;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_lo_q    <= '0;
      mem_addr_q <= '0;
      wen_q      <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      mem_addr_q <= mem_addr_d;
      wen_q      <= wen_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: doc/ysyx_23060332_wbu.md
YSYX_23060332_WBU -- requirements
Module: ysyx_23060332_wbu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the data, address and register write data.
REQ-002 SHALL have parameter REG_AW, default 5, meaning the width of the register index.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid/in_ready, input/output, 1/1, the upstream (execute) handshake.
REQ-006 SHALL have port in_rd, input, REG_AW, the destination register.
REQ-007 SHALL have port in_data, input, DATA_W, the ALU result, or the effective address when in_is_load=1.
REQ-008 SHALL have ports in_is_load and in_funct3, input, 1 and 3, the load flag and the RV32 load size/sign code.
REQ-009 SHALL have ports mem_req_valid/mem_req_ready, output/input, 1/1, and mem_addr, output, DATA_W, the word-aligned read request.
REQ-010 SHALL have ports mem_rsp_valid, input, 1, and mem_rdata, input, DATA_W, the read response.
REQ-011 SHALL have ports wen, output, 1; rd, output, REG_AW; wdata, output, DATA_W; these drive the register-file write port.
REQ-012 SHALL have port misalign, output, 1, a one-cycle error pulse.

Function
REQ-013 SHALL implement the states IDLE, REQ, WAIT and WRITE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an accept occurs when in_valid and in_ready are both high.
REQ-015 On a non-load accept, SHALL register wen=(in_rd!=0), rd and wdata=in_data the next cycle (latency 1) and stay in IDLE, so back-to-back accepts write every cycle.
REQ-016 On a load accept with a legal alignment, SHALL latch rd, funct3 and addr[1:0], drive mem_addr={addr[DATA_W-1:2],2'b00}, and go to REQ.
REQ-017 In REQ, SHALL hold mem_req_valid=1 and mem_addr stable until mem_req_ready, then go to WAIT.
REQ-018 In WAIT, SHALL extract from mem_rdata when mem_rsp_valid=1: LB/LBU take byte addr[1:0], LH/LHU take half addr[1]; the data is sign-extended (LB, LH) or zero-extended (LBU, LHU); then go to WRITE.
REQ-019 In WRITE, SHALL pulse wen=(rd!=0) for exactly 1 cycle with the extracted data, then go to IDLE; the load latency is 3 cycles plus the memory wait cycles.
REQ-020 A load is misaligned when it is LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 is 3, 6 or 7.
REQ-021 A misaligned load SHALL pulse misalign the next cycle, issue no request, perform no write, and remain in IDLE.
REQ-022 SHALL never assert wen for rd==0.
REQ-023 SHALL ignore mem_rsp_valid outside WAIT.
REQ-024 In WAIT, SHALL ignore mem_req_ready.

Reset
REQ-025 When rst is asserted, at any time including mid-load, SHALL immediately force the state to IDLE and clear wen, rd, wdata, misalign and mem_req_valid, which return to 0.
REQ-026 SHALL drop any in-flight load on reset; a response arriving after reset SHALL be ignored.

Configuration
REQ-027 With YSYX_23060332_WB_FWD_EN defined, SHALL add outputs fwd_valid, fwd_rd and fwd_data that mirror wen, rd and wdata combinationally for decode bypass.
REQ-028 Without YSYX_23060332_WB_FWD_EN, those ports SHALL be absent.

Structure
REQ-029 Package ysyx_23060332_pkg SHALL hold the WBU state enum and the LB/LH/LW/LBU/LHU funct3 constants.
REQ-030 Sub-module ysyx_23060332_ldext SHALL be the combinational byte/half select and extend, instantiated once.

Verification
REQ-031 Directed test: non-load in_rd=5, in_data=0x1234 -> next cycle wen=1, rd=5, wdata=0x1234.
REQ-032 Directed test: three back-to-back non-loads -> three consecutive wen pulses and in_ready held at 1.
REQ-033 Directed test: LB at addr 0x103, mem_rdata=0x80FFFFFF, mem_req_ready delayed 2 cycles -> mem_addr=0x100 held stable through the stall, then wdata=0xFFFFFF80.
REQ-034 Directed test: LHU at addr 0x102, mem_rdata=0xBEEF0000 -> wdata=0x0000BEEF, then a single wen pulse.
REQ-035 Directed test: LW at addr 0x101 -> misalign pulse, mem_req_valid stays 0, no wen.
REQ-036 Directed test: rst asserted during WAIT, followed by a late mem_rsp_valid -> state IDLE, no wen; also a non-load with in_rd=0 -> no wen.
